// File: rtl/spi_photon_counter.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// spi_photon_counter
//
// SPI-controlled 32-bit photon/pulse counter. An SPI mode-0 master sends
// 32-bit command words. CMD_START clears the count and enables counting, and
// CMD_STOP freezes it. In the same full-duplex transfer the master reads back
// the count value captured when SS fell. All logic runs on the single clock
// clk. SCLK, SS, MOSI and sig are treated as asynchronous inputs.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   SCLK     in   1  SPI clock from the master (<= clk/8)
//   SS       in   1  SPI slave select, active-low
//   MOSI     in   1  master-out data, MSB first
//   MISO     out  1  slave-out data, MSB first, 0 while SS is high
//   sig      in   1  photon pulse input; its rising edges are counted
//   rx       out 32  last complete word received
//   rx_valid out  1  one-cycle pulse when rx updates
//   count    out 32  current counter value
//   counting out  1  counter enable state
// ----------------------------------------------------------------------------
module spi_photon_counter #(
  parameter logic [31:0] CMD_START   = 32'hFFFF_FFFF,
  parameter logic [31:0] CMD_STOP    = 32'h0000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SCLK,
  input  logic        SS,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        sig,
  output logic [31:0] rx,
  output logic        rx_valid,
  output logic [31:0] count,
  output logic        counting
);

  // --------------------------------------------------------------------------
  // Input synchronisers and edge-detect history
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync, sig_sync;
  logic                   sclk_hist, ss_hist, sig_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sig_sync  <= '0;
      sclk_hist <= 1'b0;
      ss_hist   <= 1'b0;
      sig_hist  <= 1'b0;
    end else begin
      sclk_sync[0] <= SCLK;
      ss_sync[0]   <= SS;
      mosi_sync[0] <= MOSI;
      sig_sync[0]  <= sig;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        ss_sync[i]   <= ss_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
        sig_sync[i]  <= sig_sync[i-1];
      end
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      ss_hist   <= ss_sync[SYNC_STAGES-1];
      sig_hist  <= sig_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ss_s, mosi_s, sig_s;
  logic sclk_rise, sclk_fall, ss_fall, sig_rise;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sig_s     = sig_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign sclk_fall = ~sclk_s & sclk_hist;
  assign ss_fall   = ~ss_s & ss_hist;
  assign sig_rise  = sig_s & ~sig_hist;

  // --------------------------------------------------------------------------
  // SPI slave shift engine
  // --------------------------------------------------------------------------
  // A frame is only active after a detected SS falling edge. Because the
  // synchronisers reset to 0, an SS already low when reset is released shows
  // no falling edge, so those bits are ignored until SS cycles high then low.
  logic        active;
  logic [4:0]  bit_cnt;
  logic [31:0] rx_shift;
  logic [31:0] tx_shift;
  logic [31:0] rx_next;

  assign rx_next = {rx_shift[30:0], mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      MISO     <= 1'b0;
      rx       <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (ss_fall) begin
        active   <= 1'b1;
        bit_cnt  <= '0;
        tx_shift <= count;
        MISO     <= count[31];
      end else if (ss_s) begin
        // SS high: any partial word is simply abandoned.
        active <= 1'b0;
        MISO   <= 1'b0;
      end else if (active) begin
        if (sclk_rise) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) begin
            rx       <= rx_next;
            rx_valid <= 1'b1;
          end
        end
        if (sclk_fall) begin
          tx_shift <= {tx_shift[30:0], 1'b0};
          MISO     <= tx_shift[30];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Command decoder and 32-bit edge counter
  // --------------------------------------------------------------------------
  // Commands take priority over a coincident sig edge: START clears to 0 and
  // STOP drops that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counting <= 1'b0;
      count    <= '0;
    end else if (rx_valid && rx == CMD_START) begin
      counting <= 1'b1;
      count    <= '0;
    end else if (rx_valid && rx == CMD_STOP) begin
      counting <= 1'b0;
    end else if (counting && sig_rise) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: tb/tb_spi_photon_counter.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_spi_photon_counter
//
// Testbench for spi_photon_counter. It drives SPI frames, checks the
// read-back, and covers the command, wrap-around, aborted-frame and
// reset-in-frame cases.
// ----------------------------------------------------------------------------
module tb_spi_photon_counter;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        SCLK  = 1'b0;
  logic        SS    = 1'b1;
  logic        MOSI  = 1'b0;
  logic        sig   = 1'b0;
  logic        MISO;
  logic [31:0] rx;
  logic        rx_valid;
  logic [31:0] count;
  logic        counting;

  int          checks   = 0;
  int          errors   = 0;
  int          rv_count = 0;
  logic [31:0] rd_word  = '0;

  typedef struct {
    logic [31:0] cmd;
    int          pulses;
    logic [31:0] exp_snap;
    logic [31:0] exp_rx;
    logic        exp_counting;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs[8];

  spi_photon_counter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SCLK     (SCLK),
    .SS       (SS),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .sig      (sig),
    .rx       (rx),
    .rx_valid (rx_valid),
    .count    (count),
    .counting (counting)
  );

  always #5 clk = ~clk;

  // Count rx_valid pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) rv_count <= rv_count + 1;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: sim time limit reached, expected finish earlier");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // SCLK half period 125 ns (4 MHz). MOSI changes while SCLK is low, and
  // MISO is sampled just before each rising edge.
  task automatic spi_clock_bits(input logic [31:0] tx, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      MOSI = tx[31-i];
      #125;
      rd_word[31-i] = MISO;
      SCLK = 1'b1;
      #125;
      SCLK = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [31:0] tx, input int n);
    rd_word = '0;
    SS = 1'b0;
    #60;
    spi_clock_bits(tx, 0, n);
    #125;
    SS   = 1'b1;
    MOSI = 1'b0;
    #200;
  endtask

  // 25 MHz pulses: 20 ns high, 20 ns low.
  task automatic pulse_sig(input int n);
    repeat (n) begin
      sig = 1'b1;
      #20;
      sig = 1'b0;
      #20;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int rv0;
    rv0 = rv_count;
    spi_frame(v.cmd, 32);
    @(negedge clk);
    checkOutput($sformatf("vec%0d rx", idx), rx, v.exp_rx);
    checkOutput($sformatf("vec%0d rx_valid_pulses", idx), rv_count - rv0, 32'd1);
    checkOutput($sformatf("vec%0d miso_snapshot", idx), rd_word, v.exp_snap);
    checkOutput($sformatf("vec%0d miso_idle", idx), {31'b0, MISO}, 32'd0);
    #3;
    pulse_sig(v.pulses);
    #100;
    @(negedge clk);
    checkOutput($sformatf("vec%0d counting", idx), {31'b0, counting}, {31'b0, v.exp_counting});
    checkOutput($sformatf("vec%0d count", idx), count, v.exp_count);
  endtask

  initial begin
    int rv0;

    // cmd, pulses after the frame, MISO snapshot, rx, counting, count
    vecs[0] = '{32'hFFFF_FFFF, 2500, 32'd0,    32'hFFFF_FFFF, 1'b1, 32'd2500};
    vecs[1] = '{32'h0000_0000, 5,    32'd2500, 32'h0000_0000, 1'b0, 32'd2500};
    vecs[2] = '{32'h1234_5678, 3,    32'd2500, 32'h1234_5678, 1'b0, 32'd2500};
    vecs[3] = '{32'hFFFF_FFFF, 7,    32'd2500, 32'hFFFF_FFFF, 1'b1, 32'd7};
    vecs[4] = '{32'h1234_5678, 4,    32'd7,    32'h1234_5678, 1'b1, 32'd11};
    vecs[5] = '{32'hFFFF_FFFF, 0,    32'd11,   32'hFFFF_FFFF, 1'b1, 32'd0};
    vecs[6] = '{32'h0000_0000, 2,    32'd0,    32'h0000_0000, 1'b0, 32'd0};
    vecs[7] = '{32'hA5A5_0F0F, 0,    32'd0,    32'hA5A5_0F0F, 1'b0, 32'd0};

    // Reset held with sig toggling, then released with no START.
    #3;
    pulse_sig(10);
    @(negedge clk);
    checkOutput("reset MISO", {31'b0, MISO}, 32'd0);
    checkOutput("reset rx", rx, 32'd0);
    checkOutput("reset rx_valid", {31'b0, rx_valid}, 32'd0);
    checkOutput("reset count", count, 32'd0);
    checkOutput("reset counting", {31'b0, counting}, 32'd0);
    #2;
    rst_n = 1'b1;
    #100;
    pulse_sig(5);
    #100;
    @(negedge clk);
    checkOutput("post_reset count", count, 32'd0);
    checkOutput("post_reset counting", {31'b0, counting}, 32'd0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // Aborted frame: 16 bits, then SS rises.
    rv0 = rv_count;
    rd_word = '0;
    SS = 1'b0;
    #60;
    spi_clock_bits(32'hDEAD_BEEF, 0, 16);
    #125;
    SS = 1'b1;
    #200;
    @(negedge clk);
    checkOutput("abort rx_valid_pulses", rv_count - rv0, 32'd0);
    checkOutput("abort rx", rx, 32'hA5A5_0F0F);
    checkOutput("abort MISO", {31'b0, MISO}, 32'd0);

    // Wrap-around from FFFF_FFFE with three pulses.
    spi_frame(32'hFFFF_FFFF, 32);
    @(negedge clk);
    checkOutput("wrap start rx", rx, 32'hFFFF_FFFF);
    checkOutput("wrap counting", {31'b0, counting}, 32'd1);
    force dut.count = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.count;
    @(negedge clk);
    checkOutput("wrap preload", count, 32'hFFFF_FFFE);
    #3;
    pulse_sig(3);
    #100;
    @(negedge clk);
    checkOutput("wrap count", count, 32'h0000_0001);

    // Reset at bit 10 of a START frame; SS stays low through the release.
    rv0 = rv_count;
    SS = 1'b0;
    #60;
    spi_clock_bits(32'hFFFF_FFFF, 0, 10);
    rst_n = 1'b0;
    #20;
    @(negedge clk);
    checkOutput("midreset counting", {31'b0, counting}, 32'd0);
    checkOutput("midreset count", count, 32'd0);
    checkOutput("midreset rx", rx, 32'd0);
    checkOutput("midreset MISO", {31'b0, MISO}, 32'd0);
    #2;
    rst_n = 1'b1;
    spi_clock_bits(32'hFFFF_FFFF, 10, 22);
    #125;
    @(negedge clk);
    checkOutput("midreset tail rx_valid_pulses", rv_count - rv0, 32'd0);
    checkOutput("midreset tail counting", {31'b0, counting}, 32'd0);
    SS = 1'b1;
    #200;
    rv0 = rv_count;
    spi_frame(32'hFFFF_FFFF, 32);
    @(negedge clk);
    checkOutput("restart rx", rx, 32'hFFFF_FFFF);
    checkOutput("restart rx_valid_pulses", rv_count - rv0, 32'd1);
    checkOutput("restart counting", {31'b0, counting}, 32'd1);
    checkOutput("restart count", count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
